pipelined_segmented_adder: RTL and testbench



---
 rtl/pipelined_segmented_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_segmented_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_segmented_adder.sv
// Pipelined segmented adder: one SW-bit ripple per stage, valid/ready stall chain.
// Optional ADDER_SIGNED_OVF_EN adds a registered two's-complement ovf output.
module pipelined_segmented_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] c;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] cs;
  logic [STAGES-1:0] nc;
  logic [WIDTH-1:0]  r  [STAGES];
  logic [WIDTH-1:0]  ra [STAGES];
  logic [WIDTH-1:0]  rb [STAGES];
  logic [WIDTH-1:0]  sa [STAGES];
  logic [WIDTH-1:0]  sb [STAGES];
  logic [WIDTH-1:0]  sr [STAGES];
  logic [WIDTH-1:0]  nr [STAGES];
`ifdef ADDER_SIGNED_OVF_EN
  logic              msb_c;
`endif

  // Stage inputs: stage 0 takes the ports, later stages the previous registers.
  always_comb begin
    vin[0] = in_valid;
    sa[0]  = a;
    sb[0]  = b;
    cs[0]  = cin;
    sr[0]  = '0;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = v[k-1];
      sa[k]  = ra[k-1];
      sb[k]  = rb[k-1];
      cs[k]  = c[k-1];
      sr[k]  = r[k-1];
    end
  end

  // Load enables ripple back from out_ready; a stage moves if empty or draining.
  always_comb begin
    logic e;
    e = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      e     = !v[k] || e;
      en[k] = e;
    end
  end

  assign in_ready = en[0];

  // Each stage ripples its own SW-bit segment through full-adder cells.
  always_comb begin
    logic cy;
    logic x;
    logic y;
`ifdef ADDER_SIGNED_OVF_EN
    msb_c = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      cy    = cs[k];
      nr[k] = sr[k];
      for (int i = 0; i < SW; i++) begin
        x = sa[k][k*SW+i];
        y = sb[k][k*SW+i];
        nr[k][k*SW+i] = x ^ y ^ cy;
`ifdef ADDER_SIGNED_OVF_EN
        if (k * SW + i == WIDTH - 1) msb_c = cy;
`endif
        cy = (x & y) | (cy & (x ^ y));
      end
      nc[k] = cy;
    end
  end

  // Pipeline registers; data loads only alongside a valid token.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      c <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r[k]  <= '0;
        ra[k] <= '0;
        rb[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          v[k] <= vin[k];
          if (vin[k]) begin
            r[k]  <= nr[k];
            c[k]  <= nc[k];
            ra[k] <= sa[k];
            rb[k] <= sb[k];
          end
        end
      end
    end
  end

`ifdef ADDER_SIGNED_OVF_EN
  // Signed overflow travels with the last-stage result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (en[STAGES-1] && vin[STAGES-1]) begin
      ovf <= msb_c ^ nc[STAGES-1];
    end
  end
`endif

  assign out_valid = v[STAGES-1];
  assign sum       = r[STAGES-1];
  assign cout      = c[STAGES-1];

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Bench for pipelined_segmented_adder: random stream vs. arithmetic model.
// Directed cases cover reset, latency, ripple, backpressure and mid-stream reset.
module tb_pipelined_segmented_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf_w;

  pipelined_segmented_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_SIGNED_OVF_EN
    ,
    .ovf       (ovf_w)
`endif
  );

`ifndef ADDER_SIGNED_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  int n_out  = 0;

  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h want %h", tag, got, exp);
  endtask

  // Model: plain integer arithmetic, packed as {ovf, cout, sum}.
  function automatic logic [31:0] model(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic c);
    int unsigned u;
    int          s;
    logic        o;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    o = (s > 32767) || (s < -32768);
`ifndef ADDER_SIGNED_OVF_EN
    o = 1'b0;
`endif
    return {14'd0, o, u[W], u[W-1:0]};
  endfunction

  // Scoreboard: record accepts, compare emitted results in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else chk("result", {14'd0, ovf_w, cout, sum}, q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic one(input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic c, input logic [W-1:0] es,
                     input logic ec, input string tag);
    int lat;
    a = x; b = y; cin = c; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk({tag, "_lat"}, lat, S);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    cyc();
  endtask

  int base;
  int acc0;
  logic [W-1:0] hold;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    #1;
    // reset held 2 clocks with in_valid asserted
    a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    in_valid = 1'b0; rst_n = 1'b1;
    base = n_out;
    repeat (8) cyc();
    chk("rst_no_output", n_out - base, 0);

    one(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "carry_xseg");
    one(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "full_ripple");
`ifdef ADDER_SIGNED_OVF_EN
    one(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "ovf_case");
    chk("ovf_hold", ovf_w, 1);
`endif

    // back-to-back stream of 20
    out_ready = 1'b1;
    base = n_out; acc0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("stream_accepts", n_acc - acc0, 20);
    chk("stream_outputs", n_out - base, 20);

    // backpressure for 6 cycles
    out_ready = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      cyc();
    end
    chk("bp_accepts", n_acc - acc0, S);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1'b0;
    hold = sum;
    cyc(); cyc();
    chk("bp_sum_stable", sum, hold);
    chk("bp_valid_stable", out_valid, 1);
    out_ready = 1'b1;
    repeat (6) cyc();
    chk("bp_drained", q.size(), 0);

    // random valid/ready traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (i % 50 == 0) begin a = '1; b = '0; cin = 1'b1; end
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) cyc();
    chk("rand_drained", q.size(), 0);

    // reset with 3 ops in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      cyc();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    base = n_out;
    repeat (8) cyc();
    chk("midrst_no_output", n_out - base, 0);
    one(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "post_rst");

    chk("final_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
